// File: rtl/data_mem_arbiter.sv
// Two-port arbiter for the data memory: fixed port-0 priority with a
// port-1 anti-starvation boost. Optional counters: DATA_MEM_ARB_PERF_EN.
module data_mem_arbiter #(
    parameter int unsigned SIZE     = 1024,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_req,
    input  logic [1:0]  p0_size,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic [1:0]  p1_size,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        p1_err,
    output logic [31:0] data_rd_addr,
    input  logic [31:0] data_rd_data,
    output logic [1:0]  data_wr,
    output logic [31:0] data_wr_addr,
    output logic [31:0] data_wr_data,
    output logic        boost
`ifdef DATA_MEM_ARB_PERF_EN
    ,
    output logic [31:0] conflict_cnt,
    output logic [31:0] fault_cnt
`endif
);

    localparam logic [0:0]  S_NORM  = 1'b0;
    localparam logic [0:0]  S_BOOST = 1'b1;
    localparam logic [31:0] LIMIT   = 32'(SIZE);
    localparam logic [7:0]  WMAX    = 8'(MAX_WAIT);

    logic [0:0]  state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic        p0_rvalid_q, p1_rvalid_q;
    logic [31:0] p0_rdata_q, p1_rdata_q;
    logic        p0_err_q, p1_err_q;

    logic        p1_win;
    logic        any_gnt;
    logic [1:0]  sel_size;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        fault;
    logic [31:0] rd_val;

    // Port 1 only wins a contested cycle while boosted.
    always_comb begin
        p1_win  = p1_req && (!p0_req || (state_q == S_BOOST));
        p1_gnt  = p1_win;
        p0_gnt  = p0_req && !p1_win;
        any_gnt = p0_gnt || p1_gnt;
    end

    always_comb begin
        sel_size  = p1_gnt ? p1_size  : p0_size;
        sel_addr  = p1_gnt ? p1_addr  : p0_addr;
        sel_wdata = p1_gnt ? p1_wdata : p0_wdata;
        fault     = sel_addr >= LIMIT;
    end

    always_comb begin
        data_rd_addr = 32'd0;
        data_wr      = 2'd0;
        data_wr_addr = 32'd0;
        data_wr_data = 32'd0;
        rd_val       = 32'd0;
        if (any_gnt) begin
            data_rd_addr = sel_addr;
            data_wr_addr = sel_addr;
            data_wr_data = sel_wdata;
            data_wr      = fault ? 2'd0 : sel_size;
            if (sel_size == 2'd0 && !fault) begin
                rd_val = data_rd_data;
            end
        end
    end

    always_comb begin
        wait_d = wait_q;
        if (!p1_req || p1_gnt) begin
            wait_d = 8'd0;
        end else if (wait_q < WMAX) begin
            wait_d = wait_q + 8'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_NORM:  if (wait_d == WMAX) state_d = S_BOOST;
            S_BOOST: if (p1_gnt || !p1_req) state_d = S_NORM;
            default: state_d = S_NORM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_NORM;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Data and fault flag hold while the port is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_rvalid_q <= 1'b0;
            p0_rdata_q  <= 32'd0;
            p0_err_q    <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p1_rdata_q  <= 32'd0;
            p1_err_q    <= 1'b0;
        end else begin
            p0_rvalid_q <= p0_gnt;
            p1_rvalid_q <= p1_gnt;
            if (p0_gnt) begin
                p0_rdata_q <= rd_val;
                p0_err_q   <= fault;
            end
            if (p1_gnt) begin
                p1_rdata_q <= rd_val;
                p1_err_q   <= fault;
            end
        end
    end

    assign p0_rvalid = p0_rvalid_q;
    assign p0_rdata  = p0_rdata_q;
    assign p0_err    = p0_err_q;
    assign p1_rvalid = p1_rvalid_q;
    assign p1_rdata  = p1_rdata_q;
    assign p1_err    = p1_err_q;
    assign boost     = (state_q == S_BOOST);

`ifdef DATA_MEM_ARB_PERF_EN
    logic [31:0] conflict_q, fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_q <= 32'd0;
            fault_q    <= 32'd0;
        end else begin
            if (p0_req && p1_req) conflict_q <= conflict_q + 32'd1;
            if (any_gnt && fault) fault_q <= fault_q + 32'd1;
        end
    end

    assign conflict_cnt = conflict_q;
    assign fault_cnt    = fault_q;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed self-checking bench for data_mem_arbiter with a small
// word-organised memory model behind the arbiter.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req, p1_req;
    logic [1:0]  p0_size, p1_size;
    logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic        p0_err, p1_err;
    logic [31:0] data_rd_addr, data_rd_data;
    logic [1:0]  data_wr;
    logic [31:0] data_wr_addr, data_wr_data;
    logic        boost;
`ifdef DATA_MEM_ARB_PERF_EN
    logic [31:0] conflict_cnt, fault_cnt;
`endif

    int nassert = 0;
    int nfail   = 0;
    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    data_mem_arbiter #(.SIZE(1024), .MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_size(p0_size),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
        .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_size(p1_size),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
        .p1_rdata(p1_rdata), .p1_err(p1_err),
        .data_rd_addr(data_rd_addr),
        .data_rd_data(data_rd_data),
        .data_wr(data_wr),
        .data_wr_addr(data_wr_addr),
        .data_wr_data(data_wr_data),
        .boost(boost)
`ifdef DATA_MEM_ARB_PERF_EN
        ,
        .conflict_cnt(conflict_cnt),
        .fault_cnt(fault_cnt)
`endif
    );

    assign data_rd_data = mem[data_rd_addr[9:2]];

    always @(posedge clk) begin
        case (data_wr)
            2'd1: case (data_wr_addr[1:0])
                2'd0: mem[data_wr_addr[9:2]][7:0]   = data_wr_data[7:0];
                2'd1: mem[data_wr_addr[9:2]][15:8]  = data_wr_data[7:0];
                2'd2: mem[data_wr_addr[9:2]][23:16] = data_wr_data[7:0];
                default: mem[data_wr_addr[9:2]][31:24] = data_wr_data[7:0];
            endcase
            2'd2: if (data_wr_addr[1])
                mem[data_wr_addr[9:2]][31:16] = data_wr_data[15:0];
            else
                mem[data_wr_addr[9:2]][15:0] = data_wr_data[15:0];
            2'd3: mem[data_wr_addr[9:2]] = data_wr_data;
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nassert++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drv(
        input logic r0, input logic [1:0] s0,
        input logic [31:0] a0, input logic [31:0] w0,
        input logic r1, input logic [1:0] s1,
        input logic [31:0] a1, input logic [31:0] w1);
        @(negedge clk);
        p0_req = r0; p0_size = s0; p0_addr = a0; p0_wdata = w0;
        p1_req = r1; p1_size = s1; p1_addr = a1; p1_wdata = w1;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drv(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 2'd0, 32'd0, 32'd0);
    endtask

    task automatic both();
        drv(1'b1, 2'd0, 32'h10, 32'd0, 1'b1, 2'd0, 32'h20, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
        rst_n = 1'b0;
        p0_req = 0; p0_size = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_size = 0; p1_addr = 0; p1_wdata = 0;
        #2;
        chk("rst_p0_rvalid", {31'd0, p0_rvalid}, 32'd0);
        chk("rst_p1_rvalid", {31'd0, p1_rvalid}, 32'd0);
        chk("rst_p0_rdata", p0_rdata, 32'd0);
        chk("rst_p1_err", {31'd0, p1_err}, 32'd0);
        chk("rst_boost", {31'd0, boost}, 32'd0);
        chk("rst_data_wr", {30'd0, data_wr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // word write then read back through port 0
        drv(1'b1, 2'd3, 32'h10, 32'hDEADBEEF, 1'b0, 2'd0, 32'd0, 32'd0);
        chk("wr_p0_gnt", {31'd0, p0_gnt}, 32'd1);
        chk("wr_data_wr", {30'd0, data_wr}, 32'd3);
        chk("wr_addr", data_wr_addr, 32'h10);
        chk("wr_wdata", data_wr_data, 32'hDEADBEEF);
        tick();
        chk("wr_rvalid", {31'd0, p0_rvalid}, 32'd1);
        chk("wr_rdata", p0_rdata, 32'd0);
        drv(1'b1, 2'd0, 32'h10, 32'd0, 1'b0, 2'd0, 32'd0, 32'd0);
        chk("rd_p0_gnt", {31'd0, p0_gnt}, 32'd1);
        chk("rd_data_wr", {30'd0, data_wr}, 32'd0);
        chk("rd_addr", data_rd_addr, 32'h10);
        tick();
        chk("rd_rvalid", {31'd0, p0_rvalid}, 32'd1);
        chk("rd_rdata", p0_rdata, 32'hDEADBEEF);
        chk("rd_err", {31'd0, p0_err}, 32'd0);
        idle();
        chk("idle_data_wr_addr", data_wr_addr, 32'd0);
        tick();
        chk("idle_rvalid", {31'd0, p0_rvalid}, 32'd0);
        chk("idle_rdata_hold", p0_rdata, 32'hDEADBEEF);

        // contention: 4 p0 grants, then a boosted p1 grant
        for (int k = 0; k < 10; k++) begin
            both();
            chk($sformatf("c%0d_p0_gnt", k), {31'd0, p0_gnt},
                {31'd0, (k % 5) != 4});
            chk($sformatf("c%0d_p1_gnt", k), {31'd0, p1_gnt},
                {31'd0, (k % 5) == 4});
            chk($sformatf("c%0d_boost", k), {31'd0, boost},
                {31'd0, (k % 5) == 4});
            tick();
            chk($sformatf("c%0d_p1_rvalid", k), {31'd0, p1_rvalid},
                {31'd0, (k % 5) == 4});
        end
        chk("c_p0_rdata", p0_rdata, 32'hDEADBEEF);
        chk("c_p1_rdata", p1_rdata, 32'hA500_0008);
        idle();
        chk("c_boost_after", {31'd0, boost}, 32'd0);

        // port 1 out-of-range reads
        drv(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 2'd0, 32'd1024, 32'd0);
        chk("oor_p1_gnt", {31'd0, p1_gnt}, 32'd1);
        chk("oor_data_wr", {30'd0, data_wr}, 32'd0);
        tick();
        chk("oor_rvalid", {31'd0, p1_rvalid}, 32'd1);
        chk("oor_err", {31'd0, p1_err}, 32'd1);
        chk("oor_rdata", p1_rdata, 32'd0);
        drv(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 2'd0, 32'hFFFF_FFFC, 32'd0);
        tick();
        chk("top_err", {31'd0, p1_err}, 32'd1);
        chk("top_rdata", p1_rdata, 32'd0);

        // byte write at the last legal byte and one past it
        drv(1'b1, 2'd1, 32'd1023, 32'h0000_00AB, 1'b0, 2'd0, 32'd0, 32'd0);
        chk("b1023_data_wr", {30'd0, data_wr}, 32'd1);
        tick();
        chk("b1023_err", {31'd0, p0_err}, 32'd0);
        chk("b1023_mem", mem[255], 32'hAB00_00FF);
        drv(1'b1, 2'd1, 32'd1024, 32'h0000_00CD, 1'b0, 2'd0, 32'd0, 32'd0);
        chk("b1024_data_wr", {30'd0, data_wr}, 32'd0);
        tick();
        chk("b1024_err", {31'd0, p0_err}, 32'd1);
        drv(1'b1, 2'd2, 32'h22, 32'h0000_1234, 1'b0, 2'd0, 32'd0, 32'd0);
        chk("half_data_wr", {30'd0, data_wr}, 32'd2);
        tick();
        chk("half_mem", mem[8], 32'h1234_0008);
        chk("half_err", {31'd0, p0_err}, 32'd0);
`ifdef DATA_MEM_ARB_PERF_EN
        chk("perf_conflict", conflict_cnt, 32'd10);
        chk("perf_fault", fault_cnt, 32'd3);
`endif

        // p1 gives up while boosted
        for (int k = 0; k < 4; k++) begin
            both();
            tick();
        end
        chk("drop_boost_on", {31'd0, boost}, 32'd1);
        drv(1'b1, 2'd0, 32'h10, 32'd0, 1'b0, 2'd0, 32'd0, 32'd0);
        chk("drop_p0_gnt", {31'd0, p0_gnt}, 32'd1);
        tick();
        chk("drop_boost_off", {31'd0, boost}, 32'd0);
        chk("drop_p1_rvalid", {31'd0, p1_rvalid}, 32'd0);

        // reset with a partly counted wait
        for (int k = 0; k < 3; k++) both();
        rst_n = 1'b0;
        #2;
        chk("mid_rst_boost", {31'd0, boost}, 32'd0);
        idle();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            both();
            chk($sformatf("r%0d_p1_gnt", k), {31'd0, p1_gnt},
                {31'd0, k == 4});
            tick();
        end

        // reset arriving before a granted read's response
        drv(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 2'd0, 32'h20, 32'd0);
        chk("rr_p1_gnt", {31'd0, p1_gnt}, 32'd1);
        #2;
        rst_n = 1'b0;
        tick();
        chk("rr_p1_rvalid", {31'd0, p1_rvalid}, 32'd0);
        chk("rr_boost", {31'd0, boost}, 32'd0);
        idle();
        rst_n = 1'b1;
        tick();
        chk("rr_after_rvalid", {31'd0, p1_rvalid}, 32'd0);
        chk("rr_after_rdata", p1_rdata, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nassert, nfail);
        $finish;
    end

endmodule
